// File: rtl/tl_loader.sv
// TileLink-UL master that packs a byte stream into XLEN-bit Puts and holds the
// CPU in reset until the whole image has been written and acknowledged.
module tl_loader #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      SID_WIDTH = 2,
  parameter int unsigned      SOURCE_ID = 0,
  parameter logic [XLEN-1:0]  BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XLEN-1:0]        length,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   cpu_reset_hold,
  output logic                   tl_a_valid,
  input  logic                   tl_a_ready,
  output logic [2:0]             tl_a_opcode,
  output logic [2:0]             tl_a_param,
  output logic [2:0]             tl_a_size,
  output logic [SID_WIDTH-1:0]   tl_a_source,
  output logic [XLEN-1:0]        tl_a_address,
  output logic [XLEN/8-1:0]      tl_a_mask,
  output logic [XLEN-1:0]        tl_a_data,
  input  logic                   tl_d_valid,
  output logic                   tl_d_ready,
  input  logic [2:0]             tl_d_opcode,
  input  logic [1:0]             tl_d_param,
  input  logic [2:0]             tl_d_size,
  input  logic [SID_WIDTH-1:0]   tl_d_source,
  input  logic [XLEN-1:0]        tl_d_data,
  input  logic                   tl_d_corrupt,
  input  logic                   tl_d_denied
);

  localparam int unsigned BYTES  = XLEN / 8;
  localparam int unsigned LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_SEND_A, S_WAIT_D, S_DONE, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BYTES-1:0]    mask_q, mask_d;
  logic [XLEN-1:0]     buf_q, buf_d;
  logic                resp_ok;
  logic                unused_d;

  assign resp_ok = (tl_d_opcode == 3'd0) && (tl_d_source == SID_WIDTH'(SOURCE_ID)) &&
                   !tl_d_denied && !tl_d_corrupt;
  assign unused_d = ^{tl_d_param, tl_d_size, tl_d_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      mask_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          rem_d   = length;
          addr_d  = BASE_ADDR;
          lane_d  = '0;
          mask_d  = '0;
          buf_d   = '0;
          state_d = (length == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (lane_q == LANE_W'(i)) begin
              buf_d[i*8 +: 8] = in_data;
              mask_d[i]       = 1'b1;
            end
          end
          lane_d = lane_q + LANE_W'(1);
          rem_d  = rem_q - XLEN'(1);
          // Last lane and last image byte both close the word on this edge.
          if (lane_q == LANE_W'(BYTES - 1) || rem_q == XLEN'(1)) begin
            state_d = S_SEND_A;
          end
        end
      end
      S_SEND_A: begin
        if (tl_a_ready) state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (tl_d_valid) begin
          if (resp_ok) begin
            addr_d  = addr_q + XLEN'(BYTES);
            lane_d  = '0;
            mask_d  = '0;
            buf_d   = '0;
            state_d = (rem_q != '0) ? S_COLLECT : S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state alone so an async reset forces them at once.
  assign busy           = (state_q == S_COLLECT) || (state_q == S_SEND_A) || (state_q == S_WAIT_D);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign cpu_reset_hold = (state_q != S_DONE);
  assign in_ready       = (state_q == S_COLLECT);
  assign tl_a_valid     = (state_q == S_SEND_A);
  assign tl_d_ready     = (state_q == S_WAIT_D);

  assign tl_a_opcode  = (&mask_q) ? 3'd0 : 3'd1;
  assign tl_a_param   = 3'd0;
  assign tl_a_size    = 3'($clog2(BYTES));
  assign tl_a_source  = SID_WIDTH'(SOURCE_ID);
  assign tl_a_address = addr_q;
  assign tl_a_mask    = mask_q;
  assign tl_a_data    = buf_q;

endmodule

// File: tb/tb_tl_loader.sv
// Scoreboarded bench for tl_loader: byte-stream driver, A-channel monitor with
// a small memory model and an AccessAck responder.
module tb_tl_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] length;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        busy, done, error, cpu_reset_hold;
  logic        tl_a_valid, tl_a_ready;
  logic [2:0]  tl_a_opcode, tl_a_param, tl_a_size;
  logic [1:0]  tl_a_source;
  logic [31:0] tl_a_address;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_data;
  logic        tl_d_valid, tl_d_ready;
  logic [2:0]  tl_d_opcode;
  logic [1:0]  tl_d_param;
  logic [2:0]  tl_d_size;
  logic [1:0]  tl_d_source;
  logic [31:0] tl_d_data;
  logic        tl_d_corrupt, tl_d_denied;

  tl_loader #(.XLEN(32), .SID_WIDTH(2), .SOURCE_ID(0), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .error(error), .cpu_reset_hold(cpu_reset_hold),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
    .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_denied(tl_d_denied)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  img_q[$];
  logic [31:0] mem [0:15];
  int          checks = 0;
  int          fails  = 0;
  int          beats  = 0;
  int          deny_at = -1;
  bit          resp_en = 1'b1;

  // Monitor, memory model and responder: sample at negedge, drive #1 after posedge.
  initial begin
    beat_t obs, ex;
    bit a_fire, d_fire;
    tl_d_valid = 0; tl_d_opcode = 0; tl_d_param = 0; tl_d_size = 0;
    tl_d_source = 0; tl_d_data = 0; tl_d_corrupt = 0; tl_d_denied = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      a_fire = reset && tl_a_valid && tl_a_ready;
      d_fire = reset && tl_d_valid && tl_d_ready;
      if (a_fire) begin
        beats++;
        obs = '{op: tl_a_opcode, param: tl_a_param, size: tl_a_size, source: tl_a_source,
                addr: tl_a_address, mask: tl_a_mask, data: tl_a_data};
        for (int b = 0; b < 4; b++)
          if (tl_a_mask[b]) mem[tl_a_address[5:2]][b*8 +: 8] = tl_a_data[b*8 +: 8];
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL a_beat_unexpected: got %h, required no beat", obs);
        end else begin
          ex = exp_q.pop_front();
          if (obs !== ex) begin
            fails++;
            $display("FAIL a_beat: got op=%0d param=%0d size=%0d src=%0d addr=%h mask=%b data=%h, required op=%0d param=%0d size=%0d src=%0d addr=%h mask=%b data=%h",
                     obs.op, obs.param, obs.size, obs.source, obs.addr, obs.mask, obs.data,
                     ex.op, ex.param, ex.size, ex.source, ex.addr, ex.mask, ex.data);
          end
        end
      end
      @(posedge clk); #1;
      if (d_fire || !reset) tl_d_valid = 1'b0;
      if (a_fire && resp_en && reset) begin
        tl_d_valid  = 1'b1;
        tl_d_opcode = 3'd0;
        tl_d_size   = 3'd2;
        tl_d_source = 2'd0;
        tl_d_denied = (beats == deny_at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_expected(input logic [31:0] base);
    beat_t e;
    int n = img_q.size();
    for (int w = 0; w < (n + 3) / 4; w++) begin
      e = '0;
      e.size = 3'd2;
      e.addr = base + 32'(w * 4);
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < n) begin
          e.data[b*8 +: 8] = img_q[w*4 + b];
          e.mask[b] = 1'b1;
        end
      end
      e.op = (e.mask == 4'hF) ? 3'd0 : 3'd1;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [31:0] len);
    start = 1'b1; length = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes();
    bit got;
    for (int i = 0; i < img_q.size(); i++) begin
      in_valid = 1'b1; in_data = img_q[i]; got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk); got = in_ready;
        @(posedge clk); #1;
      end
      checks++;
      if (!got) begin
        fails++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted, required acceptance", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int c = 0; c < 200 && !(done || error); c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(done || error)) begin
      fails++;
      $display("FAIL load_end_timeout: done=%0b error=%0b, required one of them set", done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; length = 0; in_valid = 0; in_data = 0; tl_a_ready = 1'b1;
    #2;
    checks++;
    if ({busy, done, error, in_ready, tl_a_valid, tl_d_ready, cpu_reset_hold} !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_outputs: busy/done/err/in_rdy/a_v/d_rdy/hold=%b, required 0000001",
               {busy, done, error, in_ready, tl_a_valid, tl_d_ready, cpu_reset_hold});
    end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    img_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    push_expected(32'h0);
    pulse_start(32'd8);
    send_bytes();
    wait_end();
    checks++;
    if (done !== 1'b1 || cpu_reset_hold !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_done: done=%b hold=%b busy=%b, required 1 0 0", done, cpu_reset_hold, busy);
    end
    checks++;
    if (mem[0] !== 32'h0000_0513 || mem[1] !== 32'h0010_0593) begin
      fails++;
      $display("FAIL full_mem: mem0=%h mem1=%h, required 00000513 00100593", mem[0], mem[1]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL full_beats_left: %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_partial();
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_expected(32'h0);
    pulse_start(32'd6);
    pulse_start(32'd100);  // ignored while busy
    send_bytes();
    wait_end();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL partial_done: done=%b error=%b, required 1 0", done, error);
    end
    checks++;
    if (exp_q.size() != 0 || mem[1] !== 32'h0010_6655) begin
      fails++;
      $display("FAIL partial_result: left=%0d mem1=%h, required 0 00106655", exp_q.size(), mem[1]);
    end
  endtask

  task automatic test_a_stall();
    beat_t snap;
    int b0 = beats;
    img_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_expected(32'h0);
    tl_a_ready = 1'b0;
    pulse_start(32'd4);
    send_bytes();
    snap = '{op: tl_a_opcode, param: tl_a_param, size: tl_a_size, source: tl_a_source,
             addr: tl_a_address, mask: tl_a_mask, data: tl_a_data};
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tl_a_valid !== 1'b1 || tl_a_address !== 32'h0 || tl_a_data !== 32'hEFBE_ADDE ||
          tl_a_mask !== 4'hF || tl_a_address !== snap.addr || tl_a_data !== snap.data) begin
        fails++;
        $display("FAIL a_stall_stable: cycle %0d valid=%b addr=%h data=%h mask=%b, required 1 00000000 efbeadde 1111",
                 k, tl_a_valid, tl_a_address, tl_a_data, tl_a_mask);
      end
      @(posedge clk); #1;
    end
    tl_a_ready = 1'b1;
    wait_end();
    checks++;
    if (beats - b0 != 1 || done !== 1'b1) begin
      fails++;
      $display("FAIL a_stall_count: beats=%0d done=%b, required 1 1", beats - b0, done);
    end
  endtask

  task automatic test_denied();
    deny_at = beats + 2;
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_expected(32'h0);
    pulse_start(32'd8);
    send_bytes();
    wait_end();
    deny_at = -1;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset_hold !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL denied_state: error=%b done=%b hold=%b busy=%b, required 1 0 1 0",
               error, done, cpu_reset_hold, busy);
    end
    img_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    push_expected(32'h0);
    pulse_start(32'd4);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL denied_restart: error=%b busy=%b, required 0 1", error, busy);
    end
    send_bytes();
    wait_end();
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || mem[0] !== 32'hA4A3_A2A1) begin
      fails++;
      $display("FAIL denied_reload: done=%b left=%0d mem0=%h, required 1 0 a4a3a2a1",
               done, exp_q.size(), mem[0]);
    end
  endtask

  task automatic test_zero_length();
    int b0 = beats;
    bit saw_rdy = 0;
    pulse_start(32'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_reset_hold !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_done: done=%b busy=%b hold=%b, required 1 0 0", done, busy, cpu_reset_hold);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if (in_ready || tl_a_valid) saw_rdy = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_rdy || beats != b0) begin
      fails++;
      $display("FAIL zero_len_quiet: in_ready/a_valid seen=%b beats=%0d, required 0 0", saw_rdy, beats - b0);
    end
  endtask

  task automatic test_async_reset();
    bit seen_a = 0;
    bit reached = 0;
    resp_en = 1'b0;
    img_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    push_expected(32'h0);
    pulse_start(32'd4);
    send_bytes();
    for (int c = 0; c < 50 && !reached; c++) begin
      reached = tl_d_ready;
      if (!reached) begin @(posedge clk); #1; end
    end
    checks++;
    if (!reached) begin
      fails++;
      $display("FAIL async_wait_d: tl_d_ready=%b, required 1", tl_d_ready);
    end
    pulse_start(32'd12);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, in_ready, tl_a_valid, tl_d_ready, cpu_reset_hold} !== 7'b0000001) begin
      fails++;
      $display("FAIL async_reset_outputs: busy/done/err/in_rdy/a_v/d_rdy/hold=%b, required 0000001",
               {busy, done, error, in_ready, tl_a_valid, tl_d_ready, cpu_reset_hold});
    end
    @(posedge clk); #1; reset = 1'b1; resp_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); if (tl_a_valid || busy || in_ready || !cpu_reset_hold) seen_a = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_a || exp_q.size() != 0) begin
      fails++;
      $display("FAIL async_idle: activity=%b left=%0d, required 0 0", seen_a, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_a_stall();
    test_denied();
    test_zero_length();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tl_loader.md
Name: tl_loader

Overview:
- TileLink-UL master that streams a byte-serial program image, e.g. from a UART receiver, into memory through tl_switch.
- Takes over the job the runner's backdoor preload does today.
- Packs bytes little-endian into XLEN-bit words and issues one Put per word.
- Holds the CPU in reset until the whole image has been written and acknowledged.

Parameters:
XLEN, 32, data/address width; XLEN/8 bytes per beat.
SID_WIDTH, 2, TileLink source ID width.
SOURCE_ID, 0, value driven on tl_a_source; responses are checked against it.
BASE_ADDR, 32'h0000_0000, address of the first image byte; must be XLEN/8-aligned.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets)
start  input  1  one-cycle pulse; begins a load (ignored while busy)
length  input  XLEN  image length in bytes; sampled on an accepted start
in_valid  input  1  byte-stream valid
in_ready  output  1  byte-stream ready
in_data  input  8  byte-stream data
busy  output  1  load in progress
done  output  1  load completed; sticky until the next accepted start
error  output  1  load aborted on a bad response; sticky until the next accepted start
cpu_reset_hold  output  1  1 = hold CPU in reset
tl_a_valid/ready/opcode[3]/param[3]/size[3]/source[SID_WIDTH]/address[XLEN]/mask[XLEN/8]/data[XLEN]  A channel (master side); ready is an input, all others are outputs
tl_d_valid/ready/opcode[3]/param[2]/size[3]/source[SID_WIDTH]/data[XLEN]/corrupt/denied  D channel; ready is an output, all others are inputs

Behaviour:
- Reset: state=IDLE.
  - Outputs 0: busy, done, error, in_ready, tl_a_valid, tl_d_ready.
  - cpu_reset_hold=1.
  - Internal address, remaining count, byte lane and word buffer cleared.
- IDLE: on start=1, capture length into remaining and set addr=BASE_ADDR.
  - Clear done and error; set busy=1 and cpu_reset_hold=1.
  - If length==0, go to DONE; otherwise go to COLLECT.
- COLLECT: in_ready=1.
  - Each in_valid&&in_ready writes in_data into lane[lane_idx], sets mask bit lane_idx, lane_idx++ and remaining--.
  - When lane_idx reaches XLEN/8, or remaining hits 0, on that accepting edge go to SEND_A. in_ready drops the same edge.
- SEND_A: tl_a_valid=1 from the cycle after the last byte was accepted (1-cycle latency).
  - A fields while valid:
    - address=addr
    - size=log2(XLEN/8)
    - param=0
    - source=SOURCE_ID
    - data=packed word, unused lanes 0
  - Opcode and mask:
    - full mask: opcode=PutFullData (0), mask all ones.
    - otherwise (final partial word only): opcode=PutPartialData (1), mask = accumulated lanes.
  - All A fields are held stable until tl_a_ready.
  - On valid&&ready go to WAIT_D; tl_a_valid drops the next cycle.
- WAIT_D: tl_d_ready=1. Only one request is ever outstanding.
  - Success: tl_d_valid with opcode==AccessAck (0), source==SOURCE_ID, !denied and !corrupt.
    - addr += XLEN/8, lane_idx=0, mask and buffer cleared.
    - Next state is COLLECT if remaining>0, otherwise DONE.
  - Any other response goes to ERROR.
- DONE: done=1, busy=0, cpu_reset_hold=0. Behaves as IDLE (a new start is accepted).
- ERROR: error=1, busy=0, cpu_reset_hold=1. Behaves as IDLE (a new start is accepted).
- start while busy is ignored, with no effect on state or counters.
- addr wraps modulo 2^XLEN with no flag.
- Bytes presented while not in COLLECT are not consumed (in_ready=0).
- An asynchronous reset mid-transaction abandons it immediately: outputs go to reset values and the outstanding response, if any, is dropped.
  - The integrator must also reset the switch.
- tl_d_ready is never asserted outside WAIT_D.

Test Plan:
1. length=8, bytes 13 05 00 00 93 05 10 00, a_ready tied high, memory AccessAck after 1 cycle -> two PutFullData (0x0000 data 0x00000513, 0x0004 data 0x00100593, mask 4'hF, size 2); done=1 and cpu_reset_hold=0 after the second ack; memory matches.
2. length=6 -> second beat is PutPartialData at 0x0004, mask 4'b0011, data 0x0000_XXYY with upper lanes 0; done=1.
3. length=0 start -> done=1 on the next cycle; no A traffic; in_ready never high.
4. Hold tl_a_ready low 5 cycles during the first beat -> tl_a_valid, address, data and mask stable every cycle; exactly one beat transferred.
5. Respond with d_denied=1 on the second beat -> error=1, done=0, cpu_reset_hold=1; a new start clears error and reloads from BASE_ADDR.
6. Drive reset low in WAIT_D with a second start pulse queued during busy -> all outputs at reset values asynchronously; after release, IDLE with cpu_reset_hold=1 and no A traffic until a new start.
